// File: rtl/isp_wb_pkg.sv
// Shared types and constants for the white-balance gain engine.
// Gains are unsigned fixed point with GAIN_FRAC fractional bits.
package isp_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV_R,
        ST_DIV_B,
        ST_UPDATE
    } wb_state_e;

    function automatic int unsigned unity_gain(input int unsigned frac);
        return 32'd1 << frac;
    endfunction

    function automatic int unsigned max_gain(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // True when an ACC_W-bit sum cannot overflow over npix pixels of dw bits.
    function automatic bit acc_w_ok(input int acc_w, input int dw, input int npix);
        return acc_w >= dw + $clog2(npix);
    endfunction

endpackage

// File: rtl/wb_seq_div.sv
// Restoring divider, one quotient bit per clock, truncating.
// done is high in the cycle whose closing edge produces the last quotient bit.
module wb_seq_div #(
    parameter int DVD_W = 39,
    parameter int DVS_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic             div_by_zero
);
    localparam int CW = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem_q, rem_d, dvs_q, dvs_d, step_rem, step_dvs;
    logic [DVD_W-1:0] dq_q, dq_d, step_dq;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d, dbz_q, dbz_d;
    logic [DVS_W:0]   trial, diff;

    always_comb begin
        step_rem = start ? '0 : rem_q;
        step_dq  = start ? dividend : dq_q;
        step_dvs = start ? divisor : dvs_q;
        trial    = {step_rem, step_dq[DVD_W-1]};
        diff     = trial - {1'b0, step_dvs};
        rem_d    = rem_q;
        dq_d     = dq_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        dbz_d    = dbz_q;
        if (start || run_q) begin
            // dq shifts dividend bits out of the top and quotient bits in at the bottom
            if (trial >= {1'b0, step_dvs}) begin
                rem_d = diff[DVS_W-1:0];
                dq_d  = {step_dq[DVD_W-2:0], 1'b1};
            end else begin
                rem_d = trial[DVS_W-1:0];
                dq_d  = {step_dq[DVD_W-2:0], 1'b0};
            end
        end
        if (start) begin
            dvs_d = divisor;
            dbz_d = (divisor == '0);
            cnt_d = CW'(1);
            run_d = 1'b1;
        end else if (run_q) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DVD_W - 1)) run_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            dq_q  <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            dbz_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            dq_q  <= dq_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
            dbz_q <= dbz_d;
        end
    end

    assign done        = run_q && (cnt_q == CW'(DVD_W - 1));
    assign quotient    = dq_q;
    assign div_by_zero = dbz_q;

endmodule

// File: rtl/awb_gain_calc.sv
// Gray-world AWB: sums R/G/B over an ROI each frame, then divides ΣG by ΣR and ΣB
// on one shared sequential divider to produce the red and blue gains.
module awb_gain_calc
    import isp_wb_pkg::*;
#(
    parameter int DW        = 8,
    parameter int HDISP     = 1936,
    parameter int VDISP     = 1088,
    parameter int ROI_HS    = 8,
    parameter int ROI_HE    = 1928,
    parameter int ROI_VS    = 4,
    parameter int ROI_VE    = 1084,
    parameter int ACC_W     = 32,
    parameter int GAIN_FRAC = 7,
    parameter int GAIN_W    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              per_img_clken,
    input  logic [3*DW-1:0]   per_img_data,
    input  logic              awb_en,
    output logic [GAIN_W-1:0] out_gain_r,
    output logic [GAIN_W-1:0] out_gain_g,
    output logic [GAIN_W-1:0] out_gain_b,
    output logic              gain_valid,
    output logic              busy
);
    localparam int N       = ACC_W + GAIN_FRAC;
    localparam int HCW     = $clog2(HDISP + 1);
    localparam int VCW     = $clog2(VDISP + 1);
    localparam int ROI_PIX = (ROI_HE - ROI_HS) * (ROI_VE - ROI_VS);
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_FRAC));
    localparam logic [GAIN_W-1:0] GMAX  = GAIN_W'(max_gain(GAIN_W));

    if (!acc_w_ok(ACC_W, DW, ROI_PIX)) begin : g_acc_w_check
        $error("awb_gain_calc: ACC_W too small for the ROI pixel count");
    end

    logic [HCW-1:0]             h_cnt_q, h_cnt_d;
    logic [VCW-1:0]             v_cnt_q, v_cnt_d;
    logic [2:0][ACC_W-1:0]      acc_q, acc_d, sum_q, sum_d;
    logic [ACC_W-1:0]           pix_ext;
    logic                       h_last, v_last, fe, in_roi;
    wb_state_e                  state_q;
    logic [GAIN_W-1:0]          gain_r_q, gain_b_q, quo_r_q;
    logic                       gain_valid_q, busy_q, start_q;
    logic                       div_done, div_dbz, g_zero;
    logic [N-1:0]               div_quo;

    assign h_last = (h_cnt_q == HCW'(HDISP - 1));
    assign v_last = (v_cnt_q == VCW'(VDISP - 1));
    assign fe     = per_img_clken && h_last && v_last;
    assign in_roi = (int'(h_cnt_q) >= ROI_HS) && (int'(h_cnt_q) < ROI_HE) &&
                    (int'(v_cnt_q) >= ROI_VS) && (int'(v_cnt_q) < ROI_VE);
    assign g_zero = (sum_q[1] == '0);

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        pix_ext = '0;
        if (per_img_clken) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + VCW'(1);
            end else begin
                h_cnt_d = h_cnt_q + HCW'(1);
            end
            for (int c = 0; c < 3; c++) begin
                pix_ext  = in_roi ? ACC_W'(per_img_data[c*DW +: DW]) : '0;
                acc_d[c] = acc_q[c] + pix_ext;
            end
            // A frame ending mid-division is dropped: sums stay frozen, accumulators still clear
            if (fe) begin
                if (state_q == ST_IDLE) sum_d = acc_d;
                acc_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
        end
    end

    function automatic logic [GAIN_W-1:0] sat_gain(input logic [N-1:0] q, input logic dbz,
                                                   input logic gz);
        if (dbz) return gz ? UNITY : GMAX;
        if (q > N'(GMAX)) return GMAX;
        return q[GAIN_W-1:0];
    endfunction

    wb_seq_div #(
        .DVD_W(N),
        .DVS_W(ACC_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_q),
        .dividend   ({sum_q[1], {GAIN_FRAC{1'b0}}}),
        .divisor    ((state_q == ST_DIV_B) ? sum_q[0] : sum_q[2]),
        .done       (div_done),
        .quotient   (div_quo),
        .div_by_zero(div_dbz)
    );

    // The red quotient is captured in the first DIV_B cycle, before the blue run overwrites it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gain_r_q     <= UNITY;
            gain_b_q     <= UNITY;
            quo_r_q      <= UNITY;
            gain_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            gain_valid_q <= 1'b0;
            start_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fe && awb_en) begin
                        state_q <= ST_DIV_R;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (fe) begin
                        gain_r_q     <= UNITY;
                        gain_b_q     <= UNITY;
                        gain_valid_q <= 1'b1;
                    end
                end
                ST_DIV_R: begin
                    if (div_done) begin
                        state_q <= ST_DIV_B;
                        start_q <= 1'b1;
                    end
                end
                ST_DIV_B: begin
                    if (start_q) quo_r_q <= sat_gain(div_quo, div_dbz, g_zero);
                    if (div_done) state_q <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    gain_r_q     <= quo_r_q;
                    gain_b_q     <= sat_gain(div_quo, div_dbz, g_zero);
                    gain_valid_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_gain_r = gain_r_q;
    assign out_gain_g = UNITY;
    assign out_gain_b = gain_b_q;
    assign gain_valid = gain_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_awb_gain_calc.sv
// Bench for awb_gain_calc: full-frame 8x4, centre-ROI 8x4 and 8x1 instances
// share one pixel stream; expected gains are hand-computed.
module tb_awb_gain_calc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clken;
  logic [23:0] data;
  logic        awb_en;
  logic [11:0] gain_r [3];
  logic [11:0] gain_g [3];
  logic [11:0] gain_b [3];
  logic        gv [3];
  logic        bsy [3];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  awb_gain_calc #(.HDISP(8), .VDISP(4), .ROI_HS(0), .ROI_HE(8), .ROI_VS(0), .ROI_VE(4)) u_full (
    .clk(clk), .rst_n(rst_n), .per_img_clken(clken), .per_img_data(data), .awb_en(awb_en),
    .out_gain_r(gain_r[0]), .out_gain_g(gain_g[0]), .out_gain_b(gain_b[0]),
    .gain_valid(gv[0]), .busy(bsy[0]));

  awb_gain_calc #(.HDISP(8), .VDISP(4), .ROI_HS(2), .ROI_HE(6), .ROI_VS(1), .ROI_VE(3)) u_roi (
    .clk(clk), .rst_n(rst_n), .per_img_clken(clken), .per_img_data(data), .awb_en(awb_en),
    .out_gain_r(gain_r[1]), .out_gain_g(gain_g[1]), .out_gain_b(gain_b[1]),
    .gain_valid(gv[1]), .busy(bsy[1]));

  awb_gain_calc #(.HDISP(8), .VDISP(1), .ROI_HS(0), .ROI_HE(8), .ROI_VS(0), .ROI_VE(1)) u_line (
    .clk(clk), .rst_n(rst_n), .per_img_clken(clken), .per_img_data(data), .awb_en(awb_en),
    .out_gain_r(gain_r[2]), .out_gain_g(gain_g[2]), .out_gain_b(gain_b[2]),
    .gain_valid(gv[2]), .busy(bsy[2]));

  typedef struct {
    logic [7:0] r, g, b;
    int exp_r, exp_b;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clken = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Streams npix pixels; t_fe is the cycle in which the last (frame-end) pixel is presented.
  task automatic send_frame(input int npix, input logic [7:0] r, g, b, input bit roi_pat,
                            input bit gaps, output int t_fe);
    for (int i = 0; i < npix; i++) begin
      if (gaps) begin
        clken = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      if (roi_pat) begin
        if ((i % 8) >= 2 && (i % 8) < 6 && (i / 8) >= 1 && (i / 8) < 3) data = {8'd80, 8'd80, 8'd80};
        else data = {8'd255, 8'd0, 8'd0};
      end else begin
        data = {r, g, b};
      end
      clken = 1'b1;
      @(posedge clk);
      #1;
    end
    clken = 1'b0;
    t_fe = cyc - 1;
  endtask

  task automatic wait_gv(input int sel, input int t_fe, output int lat);
    int k = 0;
    lat = -1;
    while (lat < 0 && k < 300) begin
      @(negedge clk);
      k++;
      if (gv[sel]) lat = cyc - t_fe;
    end
  endtask

  task automatic count_gv(input int sel, input int ncyc, output int n);
    n = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (gv[sel]) n++;
    end
  endtask

  initial begin
    int t, t2, lat, n;
    data   = '0;
    awb_en = 1'b1;
    vecs[0] = '{8'd100, 8'd100, 8'd100, 128, 128};
    vecs[1] = '{8'd50, 8'd100, 8'd200, 256, 64};
    vecs[2] = '{8'd0, 8'd100, 8'd100, 4095, 128};
    vecs[3] = '{8'd0, 8'd0, 8'd0, 128, 128};

    do_reset();
    @(negedge clk);
    check("rst_gain_r", gain_r[0], 128);
    check("rst_gain_g", gain_g[0], 128);
    check("rst_gain_b", gain_b[0], 128);
    check("rst_gain_valid", gv[0], 0);
    check("rst_busy", bsy[0], 0);

    for (int i = 0; i < 4; i++) begin
      send_frame(32, vecs[i].r, vecs[i].g, vecs[i].b, 1'b0, 1'b0, t);
      @(negedge clk);
      check("vec_busy_t1", bsy[0], 1);
      wait_gv(0, t, lat);
      check("vec_latency", lat, 80);
      check("vec_gain_r", gain_r[0], vecs[i].exp_r);
      check("vec_gain_g", gain_g[0], 128);
      check("vec_gain_b", gain_b[0], vecs[i].exp_b);
      @(negedge clk);
      check("vec_gv_one_cycle", gv[0], 0);
      check("vec_busy_done", bsy[0], 0);
    end

    // ROI masking, then the same frame with random clken gaps
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      send_frame(32, 8'd0, 8'd0, 8'd0, 1'b1, pass == 1, t);
      wait_gv(1, t, lat);
      check("roi_latency", lat, 80);
      check("roi_gain_r", gain_r[1], 128);
      check("roi_gain_b", gain_b[1], 128);
      check("roi_full_gain_r", gain_r[0], 12);
      check("roi_full_gain_b", gain_b[0], 128);
    end

    // Second frame end while busy on the 8x1 instance
    do_reset();
    send_frame(8, 8'd50, 8'd100, 8'd200, 1'b0, 1'b0, t);
    send_frame(8, 8'd200, 8'd100, 8'd50, 1'b0, 1'b0, t2);
    check("skip_busy_at_fe2", bsy[2], 1);
    wait_gv(2, t, lat);
    check("skip_latency", lat, 80);
    check("skip_gain_r", gain_r[2], 256);
    check("skip_gain_b", gain_b[2], 64);
    count_gv(2, 100, n);
    check("skip_extra_gv", n, 0);
    send_frame(8, 8'd100, 8'd100, 8'd100, 1'b0, 1'b0, t);
    wait_gv(2, t, lat);
    check("fresh_latency", lat, 80);
    check("fresh_gain_r", gain_r[2], 128);
    check("fresh_gain_b", gain_b[2], 128);

    // Reset in the middle of a division
    do_reset();
    send_frame(32, 8'd50, 8'd100, 8'd200, 1'b0, 1'b0, t);
    while (cyc != t + 30) begin
      @(posedge clk);
      #1;
    end
    check("midrst_busy_before", bsy[0], 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_busy", bsy[0], 0);
    check("midrst_gain_r", gain_r[0], 128);
    check("midrst_gain_b", gain_b[0], 128);
    count_gv(0, 100, n);
    check("midrst_no_gv", n, 0);

    // awb_en low at frame end: unity gains one cycle later
    do_reset();
    send_frame(32, 8'd50, 8'd100, 8'd200, 1'b0, 1'b0, t);
    wait_gv(0, t, lat);
    check("en_pre_gain_r", gain_r[0], 256);
    awb_en = 1'b0;
    send_frame(32, 8'd50, 8'd100, 8'd200, 1'b0, 1'b0, t);
    @(negedge clk);
    check("en0_gv_t1", gv[0], 1);
    check("en0_gain_r", gain_r[0], 128);
    check("en0_gain_b", gain_b[0], 128);
    check("en0_busy", bsy[0], 0);
    @(negedge clk);
    check("en0_gv_one_cycle", gv[0], 0);
    awb_en = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/awb_gain_calc.md
# awb_gain_calc

Parametrised gray-world auto-white-balance gain engine for the ISP WB stage. It accumulates per-channel R/G/B sums over a programmable region of interest (ROI), one frame at a time. At each frame end it computes fixed-point gains R = ΣG/ΣR and B = ΣG/ΣB (G is unity) using one shared sequential divider. It sits beside the pixel stream ahead of the gain-multiply stage and updates its gain registers once per processed frame.

## Interface
Parameters:
- DW, 8: bits per colour channel.
- HDISP, 1936: active pixels per line.
- VDISP, 1088: active lines per frame.
- ROI_HS, 8: first ROI column, inclusive.
- ROI_HE, 1928: ROI column end, exclusive.
- ROI_VS, 4: first ROI line, inclusive.
- ROI_VE, 1084: ROI line end, exclusive.
- ACC_W, 32: accumulator width. Must satisfy ACC_W ≥ DW + clog2(ROI pixel count); violating this is an elaboration error.
- GAIN_FRAC, 7: fractional bits of each gain (unity = 1<<GAIN_FRAC).
- GAIN_W, 12: gain output width (unsigned, GAIN_W-GAIN_FRAC integer bits).

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset. One clock; reset is asynchronous and active-low.
- per_img_clken, in, 1: pixel valid strobe.
- per_img_data, in, 3*DW: pixel data, {R,G,B} with R in the MSBs.
- awb_en, in, 1: enable gain computation. Sampled at frame end.
- out_gain_r, out, GAIN_W: red gain.
- out_gain_g, out, GAIN_W: green gain, constant unity.
- out_gain_b, out, GAIN_W: blue gain.
- gain_valid, out, 1: one-cycle pulse when the gains update.
- busy, out, 1: high while a division sequence is in progress.

## Operation
- h_cnt/v_cnt advance only on per_img_clken. They wrap at HDISP-1 and at VDISP-1. Gaps in clken do not change the result.
- A pixel is in the ROI when ROI_HS ≤ h_cnt < ROI_HE and ROI_VS ≤ v_cnt < ROI_VE. Only ROI pixels are added to AccR/AccG/AccB.
- Frame end (FE) is per_img_clken with h_cnt==HDISP-1 and v_cnt==VDISP-1.
- On FE:
  - AccR/G/B plus the current pixel (if it is in the ROI) are copied to SumR/G/B.
  - The accumulators clear to 0, so the next frame starts clean.
- FSM states: IDLE, DIV_R, DIV_B, UPDATE.
  - IDLE → DIV_R on FE when awb_en=1.
  - DIV_R → DIV_B after N = ACC_W+GAIN_FRAC cycles.
  - DIV_B → UPDATE after N cycles.
  - UPDATE → IDLE after 1 cycle.
- Division: dividend = SumG<<GAIN_FRAC, divisor = SumC. Uses a restoring divider, one quotient bit per cycle, and truncates.
  - A quotient ≥ 2^GAIN_W saturates to 2^GAIN_W-1.
  - SumC==0 with SumG>0 gives 2^GAIN_W-1.
  - SumC==0 with SumG==0 gives unity.
- UPDATE loads out_gain_r/b from the quotients and asserts gain_valid.
- FE while busy: the sums are not re-snapshotted, that frame is skipped, and the accumulators still clear. The in-flight result completes normally.
- FE with awb_en=0 in IDLE: out_gain_r/b load unity, gain_valid pulses, and no division runs.
- out_gain_g is always unity.

## Timing
- Reset values:
  - out_gain_r, out_gain_g, out_gain_b = unity (128 at default).
  - gain_valid = 0, busy = 0.
  - Counters, accumulators and sums = 0. FSM is in IDLE.
- Let T be the cycle FE is sampled.
- Snapshot registers are valid at T+1. busy is high from T+1 through T+2N+1.
- DIV_R runs T+1..T+N, DIV_B runs T+N+1..T+2N, UPDATE is at T+2N+1.
- New gains and the gain_valid pulse are visible at T+2N+2. At defaults this is T+80.
- In the awb_en=0 path, unity gains and gain_valid appear at T+1.
- Reset mid-sequence aborts immediately: no gain_valid, outputs return to unity.

## Structure
- Shared package isp_wb_pkg holds:
  - the FSM state enum;
  - unity/max gain constants as functions of GAIN_FRAC/GAIN_W;
  - the clog2-based ACC_W check function.
- One sub-module, wb_seq_div: a parametrised restoring divider.
  - Inputs: start, dividend, divisor.
  - Outputs: done, quotient, div_by_zero.
  - It is instantiated once and shared between R and B.

## Test plan
Tests use HDISP=8, VDISP=4, full-frame ROI, default widths unless stated.
- Uniform frame R=G=B=100 → gains 128/128/128 at T+80, gain_valid high for exactly one cycle.
- Frame R=50, G=100, B=200 → out_gain_r=256, out_gain_b=64, out_gain_g=128.
- R=0, G=100, B=100 → out_gain_r=4095 (saturated), out_gain_b=128. Then all zero → all gains 128.
- ROI = centre 4×2, outside pixels {255,0,0}, inside R=G=B=80 → gains 128. Also randomised clken gaps give an identical result and latency relative to T.
- Second FE arriving during busy (VDISP=1, HDISP=8) → that frame is skipped, only one gain_valid per completed sequence. Next frame computes from fresh sums.
- rst_n pulsed at T+30 → no gain_valid, outputs 128, busy 0. awb_en=0 at FE → unity and gain_valid at T+1.
